// File: rtl/axis_packetizer_v2.sv
// AXI-Stream packetizer: frames a sample stream into packets of configurable length,
// with an optional header beat carrying {seq, len} and an idle timeout for short packets.
module axis_packetizer_v2 #(
  parameter int DATA_W    = 32,
  parameter int USER_W    = 8,
  parameter int MAX_LEN   = 256,
  parameter int TIMEOUT_W = 16,
  parameter int SEQ_W     = 16,
  localparam int LEN_W    = $clog2(MAX_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [LEN_W-1:0]     cfg_pkt_len,
  input  logic [TIMEOUT_W-1:0] cfg_timeout,
  input  logic                 cfg_hdr_en,
  input  logic [DATA_W-1:0]    s_tdata,
  input  logic [USER_W-1:0]    s_tuser,
  input  logic                 s_tvalid,
  output logic                 s_tready,
  output logic [DATA_W-1:0]    m_tdata,
  output logic [USER_W-1:0]    m_tuser,
  output logic                 m_tvalid,
  output logic                 m_tlast,
  output logic                 m_thdr,
  input  logic                 m_tready,
  output logic [31:0]          stat_pkt_cnt,
  output logic [15:0]          stat_trunc_cnt,
  output logic                 busy
);

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  // Hold stage H
  logic                 hv_reg, hv_next;
  logic [DATA_W-1:0]    h_data_reg, h_data_next;
  logic [USER_W-1:0]    h_user_reg, h_user_next;
  logic [LEN_W-1:0]     idx_reg, idx_next;
  logic [LEN_W-1:0]     len_q_reg, len_q_next;
  logic                 hdr_pend_reg, hdr_pend_next;
  logic [TIMEOUT_W-1:0] timer_reg, timer_next;
  logic [SEQ_W-1:0]     seq_reg, seq_next;

  // Output stage O
  logic                 m_tvalid_reg, m_tvalid_next;
  logic [DATA_W-1:0]    m_tdata_reg, m_tdata_next;
  logic [USER_W-1:0]    m_tuser_reg, m_tuser_next;
  logic                 m_tlast_reg, m_tlast_next;
  logic                 m_thdr_reg, m_thdr_next;

  // Statistics
  logic [31:0]          pkt_cnt_reg, pkt_cnt_next;
  logic [15:0]          trunc_cnt_reg, trunc_cnt_next;

  // Control
  logic [LEN_W-1:0]     len_clamped;
  logic                 o_free;
  logic                 h_count_last;
  logic [TIMEOUT_W:0]   timer_inc;
  logic                 timed_out;
  logic                 h_rel;
  logic                 rel_last;
  logic                 rel_trunc;
  logic                 hdr_load;
  logic                 h_load;
  logic [LEN_W-1:0]     load_idx;
  logic                 first_load;
  logic [15:0]          len_ext;
  logic [DATA_W-1:0]    hdr_word;

  always_comb begin
    len_clamped = cfg_pkt_len;
    if (cfg_pkt_len == '0) begin
      len_clamped = LEN_W'(1);
    end else if (cfg_pkt_len > MAX_LEN_L) begin
      len_clamped = MAX_LEN_L;
    end
  end

  assign o_free       = !m_tvalid_reg || m_tready;
  // idx counts beats loaded so far, so the beat in H is count-last when idx equals len.
  assign h_count_last = hv_reg && (idx_reg == len_q_reg);
  assign timer_inc    = {1'b0, timer_reg} + {{TIMEOUT_W{1'b0}}, 1'b1};
  assign timed_out    = hv_reg && !hdr_pend_reg && (cfg_timeout != '0)
                        && (timer_inc >= {1'b0, cfg_timeout});

  assign h_rel     = hv_reg && o_free && !hdr_pend_reg
                     && (h_count_last || s_tvalid || timed_out);
  assign rel_last  = h_count_last || !s_tvalid;
  assign rel_trunc = h_rel && !h_count_last && !s_tvalid;
  assign hdr_load  = o_free && hdr_pend_reg;

  assign s_tready   = rst_n && (!hv_reg || h_rel);
  assign h_load     = s_tvalid && s_tready;
  // A beat arriving alongside a closing release starts the next packet.
  assign load_idx   = (h_rel && rel_last) ? '0 : idx_reg;
  assign first_load = h_load && (load_idx == '0);

  assign len_ext = 16'(len_q_reg);

  generate
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_hdr
      if (gi < 16) begin : g_len
        assign hdr_word[gi] = len_ext[gi];
      end else if (gi < 16 + SEQ_W) begin : g_seq
        assign hdr_word[gi] = seq_reg[gi-16];
      end else begin : g_zero
        assign hdr_word[gi] = 1'b0;
      end
    end
  endgenerate

  always_comb begin
    hv_next       = hv_reg;
    h_data_next   = h_data_reg;
    h_user_next   = h_user_reg;
    idx_next      = idx_reg;
    len_q_next    = len_q_reg;
    hdr_pend_next = hdr_pend_reg;
    timer_next    = timer_reg;
    seq_next      = seq_reg;

    if (h_load) begin
      hv_next     = 1'b1;
      h_data_next = s_tdata;
      h_user_next = s_tuser;
      idx_next    = load_idx + LEN_W'(1);
    end else if (h_rel) begin
      hv_next = 1'b0;
      if (rel_last) begin
        idx_next = '0;
      end
    end

    if (first_load) begin
      len_q_next    = len_clamped;
      hdr_pend_next = cfg_hdr_en;
    end else if (hdr_load) begin
      hdr_pend_next = 1'b0;
    end

    // Saturating so an expiry stays asserted while O is stalled.
    if (h_load || h_rel) begin
      timer_next = '0;
    end else if (hv_reg && !hdr_pend_reg && (timer_reg != '1)) begin
      timer_next = timer_reg + TIMEOUT_W'(1);
    end

    if (h_rel && rel_last) begin
      seq_next = seq_reg + SEQ_W'(1);
    end
  end

  always_comb begin
    m_tvalid_next = m_tvalid_reg;
    m_tdata_next  = m_tdata_reg;
    m_tuser_next  = m_tuser_reg;
    m_tlast_next  = m_tlast_reg;
    m_thdr_next   = m_thdr_reg;

    if (hdr_load) begin
      m_tvalid_next = 1'b1;
      m_tdata_next  = hdr_word;
      m_tuser_next  = '0;
      m_tlast_next  = 1'b0;
      m_thdr_next   = 1'b1;
    end else if (h_rel) begin
      m_tvalid_next = 1'b1;
      m_tdata_next  = h_data_reg;
      m_tuser_next  = h_user_reg;
      m_tlast_next  = rel_last;
      m_thdr_next   = 1'b0;
    end else if (m_tready) begin
      m_tvalid_next = 1'b0;
    end
  end

  always_comb begin
    pkt_cnt_next   = pkt_cnt_reg;
    trunc_cnt_next = trunc_cnt_reg;
    if (m_tvalid_reg && m_tready && m_tlast_reg) begin
      pkt_cnt_next = pkt_cnt_reg + 32'd1;
    end
    if (rel_trunc && (trunc_cnt_reg != 16'hFFFF)) begin
      trunc_cnt_next = trunc_cnt_reg + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hv_reg       <= 1'b0;
      h_data_reg   <= '0;
      h_user_reg   <= '0;
      idx_reg      <= '0;
      len_q_reg    <= '0;
      hdr_pend_reg <= 1'b0;
      timer_reg    <= '0;
      seq_reg      <= '0;
    end else begin
      hv_reg       <= hv_next;
      h_data_reg   <= h_data_next;
      h_user_reg   <= h_user_next;
      idx_reg      <= idx_next;
      len_q_reg    <= len_q_next;
      hdr_pend_reg <= hdr_pend_next;
      timer_reg    <= timer_next;
      seq_reg      <= seq_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_tvalid_reg <= 1'b0;
      m_tdata_reg  <= '0;
      m_tuser_reg  <= '0;
      m_tlast_reg  <= 1'b0;
      m_thdr_reg   <= 1'b0;
    end else begin
      m_tvalid_reg <= m_tvalid_next;
      m_tdata_reg  <= m_tdata_next;
      m_tuser_reg  <= m_tuser_next;
      m_tlast_reg  <= m_tlast_next;
      m_thdr_reg   <= m_thdr_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt_reg   <= '0;
      trunc_cnt_reg <= '0;
    end else begin
      pkt_cnt_reg   <= pkt_cnt_next;
      trunc_cnt_reg <= trunc_cnt_next;
    end
  end

  assign m_tvalid       = m_tvalid_reg;
  assign m_tdata        = m_tdata_reg;
  assign m_tuser        = m_tuser_reg;
  assign m_tlast        = m_tlast_reg;
  assign m_thdr         = m_thdr_reg;
  assign stat_pkt_cnt   = pkt_cnt_reg;
  assign stat_trunc_cnt = trunc_cnt_reg;
  assign busy           = hv_reg || m_tvalid_reg || (idx_reg != '0);

endmodule

// File: tb/tb_axis_packetizer_v2.sv
// Scoreboard bench for axis_packetizer_v2: a stream-level packet model predicts every
// output beat; independent monitors compare outputs and check stall stability.
`timescale 1ns/1ps
module tb_axis_packetizer_v2;
  localparam int DATA_W    = 32;
  localparam int USER_W    = 8;
  localparam int MAX_LEN   = 256;
  localparam int TIMEOUT_W = 16;
  localparam int SEQ_W     = 16;
  localparam int LEN_W     = $clog2(MAX_LEN + 1);

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [LEN_W-1:0]     cfg_pkt_len;
  logic [TIMEOUT_W-1:0] cfg_timeout;
  logic                 cfg_hdr_en;
  logic [DATA_W-1:0]    s_tdata;
  logic [USER_W-1:0]    s_tuser;
  logic                 s_tvalid;
  logic                 s_tready;
  logic [DATA_W-1:0]    m_tdata;
  logic [USER_W-1:0]    m_tuser;
  logic                 m_tvalid, m_tlast, m_thdr;
  logic                 m_tready;
  logic [31:0]          stat_pkt_cnt;
  logic [15:0]          stat_trunc_cnt;
  logic                 busy;

  axis_packetizer_v2 #(
    .DATA_W(DATA_W), .USER_W(USER_W), .MAX_LEN(MAX_LEN),
    .TIMEOUT_W(TIMEOUT_W), .SEQ_W(SEQ_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_pkt_len(cfg_pkt_len), .cfg_timeout(cfg_timeout), .cfg_hdr_en(cfg_hdr_en),
    .s_tdata(s_tdata), .s_tuser(s_tuser), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tuser(m_tuser), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
    .m_thdr(m_thdr), .m_tready(m_tready),
    .stat_pkt_cnt(stat_pkt_cnt), .stat_trunc_cnt(stat_trunc_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              hdr;
    logic              last;
    logic [USER_W-1:0] user;
    logic [DATA_W-1:0] data;
  } beat_t;

  beat_t exp_q[$];
  int    pop_cyc[$];
  int    n_checks = 0;
  int    n_pass = 0;
  int    cyc = 0;
  bit    rand_ready = 1'b0;

  // Packet model state
  int pos = 0;
  int len_cur = 1;
  int seq_m = 0;
  int exp_pkts = 0;
  int exp_trunc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, got, exp);
  endtask

  function automatic int clamp_len(input int l);
    if (l == 0) return 1;
    if (l > MAX_LEN) return MAX_LEN;
    return l;
  endfunction

  task automatic model_accept(input logic [DATA_W-1:0] d, input logic [USER_W-1:0] u);
    beat_t b;
    if (pos == 0) begin
      len_cur = clamp_len(int'(cfg_pkt_len));
      if (cfg_hdr_en) begin
        b.hdr  = 1'b1;
        b.last = 1'b0;
        b.user = '0;
        b.data = DATA_W'(longint'(seq_m) * 65536 + longint'(len_cur));
        exp_q.push_back(b);
      end
    end
    b.hdr  = 1'b0;
    b.last = (pos == len_cur - 1);
    b.user = u;
    b.data = d;
    exp_q.push_back(b);
    pos++;
    if (b.last) begin
      pos = 0;
      seq_m = (seq_m + 1) % (1 << SEQ_W);
      exp_pkts++;
    end
  endtask

  // Stimulus knows it will go idle long enough: the newest beat closes its packet.
  task automatic mark_trunc();
    beat_t t;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL mark_trunc: got empty expectation queue required pending beat");
    end else begin
      t = exp_q[exp_q.size()-1];
      t.last = 1'b1;
      exp_q[exp_q.size()-1] = t;
      pos = 0;
      seq_m = (seq_m + 1) % (1 << SEQ_W);
      exp_pkts++;
      exp_trunc++;
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    pos = 0;
    seq_m = 0;
    exp_pkts = 0;
    exp_trunc = 0;
  endtask

  always @(negedge clk) begin
    if (rst_n && s_tvalid && s_tready) model_accept(s_tdata, s_tuser);
  end

  always @(negedge clk) begin
    beat_t got;
    beat_t e;
    if (rst_n && m_tvalid && m_tready) begin
      got = {m_thdr, m_tlast, m_tuser, m_tdata};
      pop_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL out_unexpected: got beat %h required no output", got);
      end else begin
        e = exp_q.pop_front();
        chk("out_beat", 64'(got), 64'(e));
      end
    end
  end

  logic  stalled = 1'b0;
  beat_t held;
  always @(negedge clk) begin
    if (rst_n && stalled)
      chk("stall_stable", 64'({m_tvalid, m_thdr, m_tlast, m_tuser, m_tdata}), 64'({1'b1, held}));
    stalled <= rst_n && m_tvalid && !m_tready;
    held    <= {m_thdr, m_tlast, m_tuser, m_tdata};
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) m_tready = 1'($urandom_range(1, 0));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by 500us required finish");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [DATA_W-1:0] d, output int acc_cyc);
    int guard;
    guard = 0;
    s_tdata  = d;
    s_tuser  = USER_W'($urandom);
    s_tvalid = 1'b1;
    forever begin
      @(negedge clk);
      if (s_tready) break;
      guard++;
      if (guard > 2000) begin
        n_checks++;
        $display("FAIL send_timeout: got s_tready low 2000 cycles for beat %h required high", d);
        break;
      end
    end
    @(posedge clk);
    #1;
    acc_cyc  = cyc;
    s_tvalid = 1'b0;
  endtask

  task automatic drain(input string name);
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 5000) begin
      @(posedge clk);
      guard++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk({name, "_drained"}, 64'(exp_q.size()), 64'(0));
  endtask

  task automatic reset_dut();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;
  endtask

  initial begin
    int c, c0, base;
    bit seen;
    cfg_pkt_len = '0;
    cfg_timeout = '0;
    cfg_hdr_en  = 1'b0;
    s_tdata     = '0;
    s_tuser     = '0;
    s_tvalid    = 1'b0;
    m_tready    = 1'b1;

    // Reset state
    #2;
    chk("rst_s_tready", 64'(s_tready), 64'(0));
    chk("rst_m_tvalid", 64'(m_tvalid), 64'(0));
    chk("rst_m_payload", 64'({m_tdata, m_tuser, m_tlast, m_thdr}), 64'(0));
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("post_rst_s_tready", 64'(s_tready), 64'(1));
    chk("post_rst_busy", 64'(busy), 64'(0));
    chk("post_rst_stats", 64'({stat_pkt_cnt, stat_trunc_cnt}), 64'(0));

    // Test 1: len=4, no header, back-to-back
    cfg_pkt_len = LEN_W'(4);
    base = pop_cyc.size();
    for (int i = 0; i < 8; i++) send(DATA_W'(i), c);
    drain("t1");
    if (pop_cyc.size() >= base + 8) chk("t1_no_gaps", 64'(pop_cyc[base+7] - pop_cyc[base]), 64'(7));
    else chk("t1_beats_out", 64'(pop_cyc.size() - base), 64'(8));
    chk("t1_pkt_cnt", 64'(stat_pkt_cnt), 64'(exp_pkts));

    // Test 2: len=3 with headers
    reset_dut();
    cfg_pkt_len = LEN_W'(3);
    cfg_hdr_en  = 1'b1;
    for (int i = 0; i < 6; i++) send(DATA_W'(32'h100 + i), c);
    drain("t2");
    chk("t2_pkt_cnt", 64'(stat_pkt_cnt), 64'(exp_pkts));

    // Test 3: idle timeout closes a short packet
    reset_dut();
    cfg_pkt_len = LEN_W'(8);
    cfg_timeout = TIMEOUT_W'(10);
    send(DATA_W'(32'h200), c);
    send(DATA_W'(32'h201), c);
    send(DATA_W'(32'h202), c0);
    mark_trunc();
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (m_tvalid && m_tlast && !m_thdr) begin
        seen = 1'b1;
        break;
      end
    end
    chk("t3_trunc_latency", seen ? 64'(cyc - c0) : 64'hFFFF, 64'(10));
    chk("t3_trunc_cnt", 64'(stat_trunc_cnt), 64'(exp_trunc));
    send(DATA_W'(32'h203), c);
    send(DATA_W'(32'h204), c);
    mark_trunc();
    repeat (20) @(posedge clk);
    drain("t3");
    chk("t3_trunc_cnt2", 64'(stat_trunc_cnt), 64'(exp_trunc));
    chk("t3_pkt_cnt", 64'(stat_pkt_cnt), 64'(exp_pkts));
    cfg_timeout = '0;

    // Test 4: random valid/ready, len=16
    cfg_pkt_len = LEN_W'(16);
    cfg_hdr_en  = 1'b0;
    rand_ready  = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      while ($urandom_range(1, 0) == 0) begin
        @(posedge clk);
        #1;
      end
      send(DATA_W'($urandom), c);
    end
    mark_trunc();
    cfg_timeout = TIMEOUT_W'(5);
    drain("t4");
    cfg_timeout = '0;
    rand_ready  = 1'b0;
    @(posedge clk);
    #1;
    m_tready = 1'b1;
    chk("t4_pkt_cnt", 64'(stat_pkt_cnt), 64'(exp_pkts));
    chk("t4_trunc_cnt", 64'(stat_trunc_cnt), 64'(exp_trunc));

    // Test 5: length changes mid-packet, zero and oversize lengths
    cfg_pkt_len = LEN_W'(4);
    send(DATA_W'(32'h500), c);
    send(DATA_W'(32'h501), c);
    cfg_pkt_len = LEN_W'(6);
    for (int i = 2; i < 10; i++) send(DATA_W'(32'h500 + i), c);
    cfg_pkt_len = '0;
    for (int i = 0; i < 3; i++) send(DATA_W'(32'h600 + i), c);
    cfg_pkt_len = LEN_W'(300);
    for (int i = 0; i < 256; i++) send(DATA_W'(32'h700 + i), c);
    drain("t5");
    chk("t5_pkt_cnt", 64'(stat_pkt_cnt), 64'(exp_pkts));
    chk("t5_busy_idle", 64'(busy), 64'(0));

    // Test 6: asynchronous reset while O holds a beat
    cfg_pkt_len = LEN_W'(3);
    cfg_hdr_en  = 1'b1;
    m_tready    = 1'b0;
    send(DATA_W'(32'h800), c);
    repeat (2) @(posedge clk);
    #1;
    chk("t6_pre_valid", 64'(m_tvalid), 64'(1));
    chk("t6_pre_busy", 64'(busy), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_m_tvalid", 64'(m_tvalid), 64'(0));
    chk("t6_rst_s_tready", 64'(s_tready), 64'(0));
    chk("t6_rst_m_tdata", 64'(m_tdata), 64'(0));
    chk("t6_rst_busy", 64'(busy), 64'(0));
    model_reset();
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    m_tready = 1'b1;
    #1;
    chk("t6_post_stats", 64'({stat_pkt_cnt, stat_trunc_cnt}), 64'(0));
    chk("t6_post_s_tready", 64'(s_tready), 64'(1));
    for (int i = 0; i < 3; i++) send(DATA_W'(32'h900 + i), c);
    drain("t6");
    chk("t6_pkt_cnt", 64'(stat_pkt_cnt), 64'(exp_pkts));
    chk("t6_trunc_cnt", 64'(stat_trunc_cnt), 64'(exp_trunc));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axis_packetizer_v2.md
Name: axis_packetizer_v2

Overview:
Parametrised successor to the fixed 256-beat AXI-Stream packetizer in the DAQ sample path. It frames a continuous sample stream into packets of runtime-configurable length and can insert an optional header beat carrying a sequence number and the packet length. An idle timeout closes short packets when the sample source stalls. It sits between the sample source (slave side) and the DMA/FIFO sink (master side), with full tready back-pressure propagation.

Parameters:
DATA_W, 32, stream data width; must be >= 32.
USER_W, 8, tuser width; passed through on data beats.
MAX_LEN, 256, maximum data beats per packet; LEN_W = $clog2(MAX_LEN+1), must be <= 16.
TIMEOUT_W, 16, width of the idle-timeout counter and config.
SEQ_W, 16, sequence-number width; must be <= DATA_W-16.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cfg_pkt_len  in  LEN_W  data beats per packet; 0 is treated as 1; values > MAX_LEN are clamped to MAX_LEN
cfg_timeout  in  TIMEOUT_W  idle cycles before a short packet is closed; 0 disables the timeout
cfg_hdr_en  in  1  insert a header beat before each packet
s_tdata/s_tuser/s_tvalid  in  DATA_W/USER_W/1  slave stream
s_tready  out  1  slave ready
m_tdata/m_tuser  out  DATA_W/USER_W  master stream payload
m_tvalid/m_tlast/m_thdr  out  1 each  master valid, last beat of packet, header-beat marker
m_tready  in  1  master ready
stat_pkt_cnt  out  32  count of packets completed on m (tlast handshakes); wraps
stat_trunc_cnt  out  16  count of timeout-truncated packets; saturates at 0xFFFF
busy  out  1  hv || m_tvalid || idx != 0

Behaviour:
- Reset (async assert, sync deassert by system):
  - Clears hold register H (hv=0), output register O (m_tvalid=0), idx, seq, timer and stats.
  - During reset m_tdata=0, m_tuser=0, m_tlast=0, m_thdr=0, s_tready=0.
  - After release s_tready=1.
  - Reset mid-packet discards in-flight beats with no partial tlast.
- Config latch: cfg_pkt_len (clamped) and cfg_hdr_en are latched into len_q/hdr_q when the first beat of a packet (idx=0) enters H. Mid-packet cfg changes take effect on the next packet. cfg_timeout is used live.
- Two-stage datapath: one-entry hold H, then output register O that drives m_*.
  - O loads only when o_free = !m_tvalid || m_tready.
  - m_* are stable while m_tvalid && !m_tready.
- s_tready = !hv || h_rel, where h_rel means H moves to O this cycle.
- Header:
  - When a packet's first beat enters H and hdr_q=1, a header is pending.
  - On the next o_free cycle O loads m_tdata = {zeros, seq, 16'(len_q)} (len in [15:0], seq in [16+SEQ_W-1:16]), with m_thdr=1, m_tlast=0, m_tuser=0.
  - H cannot release while a header is pending.
- H release (needs o_free and no pending header), on any one of:
  - (a) H is count-last (idx of H == len_q-1): release immediately with tlast=1.
  - (b) s_tvalid=1: a successor exists, release with tlast=0 while the successor loads into H in the same cycle.
  - (c) timeout: H has sat for cfg_timeout consecutive cycles with no successor and no pending header. Release with tlast=1 and m_tuser = the held beat's value; stat_trunc_cnt +1.
- Release priority is (a) > (b) > (c).
- Timer: cleared on H load; increments each cycle H is held with no header pending; compared while o_free is low too (expiry is sticky until release).
- idx: increments on each H load and returns to 0 after a tlast release.
- seq: increments (wrap mod 2^SEQ_W) on every tlast release into O.
- Simultaneous events:
  - Timeout expiring in the same cycle s_tvalid rises: (b) wins, no truncation.
  - A count-last beat never waits for a successor.
- Throughput and latency:
  - Steady state is 1 beat/cycle with hdr off; one bubble per packet with hdr on.
  - Count-last beat: 1 cycle from H load to m_tvalid.
  - Other beats: until successor arrival or timeout.
- stat_pkt_cnt increments on m_tvalid && m_tready && m_tlast.

Test Plan:
1. len=4, hdr off, timeout=0, 8 beats 0..7 back-to-back, m_tready=1 -> m_tlast on data 3 and 7 only; stat_pkt_cnt=2; no gaps after first beat.
2. len=3, hdr on, 6 beats -> m sequence: header 0x0000_0003 (m_thdr=1), D0,D1,D2(tlast), header 0x0001_0003, D3,D4,D5(tlast).
3. len=8, timeout=10, hdr on, send 3 beats then idle -> 3rd beat emitted with tlast exactly 10 cycles after entering H; stat_trunc_cnt=1. Next beat gets header seq=1 and idx restarts at 0.
4. len=16, 1000 random beats, s_tvalid and m_tready each random 50% -> output data order exact, no loss or duplication, tlast every 16th beat, m_* stable while stalled.
5. cfg_pkt_len 4->6 written after beat 1 of a packet; then cfg_pkt_len=0; then 300 -> first packet closes at 4, next at 6; then tlast on every beat; then on beat 256 (clamped).
6. rst_n pulsed low mid-packet with m_tvalid=1 -> m_tvalid=0 and s_tready=0 immediately (async). After release, stats=0 and the first header carries seq=0.
